// File: rtl/bru_pkg.sv
// Shared constants, types and the saturating-counter helper for the branch
// resolution unit and its bimodal predictor.
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {S_INIT, S_RUN} state_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_ST) res = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bru_cmp.sv
// Branch operand comparator: one XLEN+1-bit subtraction yields equality,
// signed less-than and unsigned less-than.
module bru_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  logic [XLEN:0] sub;
  logic          ovf;

  assign sub = {1'b0, rs1} + {1'b0, ~rs2} + {{XLEN{1'b0}}, 1'b1};
  // Signed overflow: operands differ in sign and the result sign differs from rs1.
  assign ovf = (rs1[XLEN-1] ^ rs2[XLEN-1]) & (sub[XLEN-1] ^ rs1[XLEN-1]);
  assign eq  = (sub[XLEN-1:0] == '0);
  assign lt  = sub[XLEN-1] ^ ovf;
  assign ltu = ~sub[XLEN];

endmodule

// File: rtl/bru_bht.sv
// Branch resolution unit with bimodal 2-bit predictor and direct-mapped BTB.
// IF-side lookup is combinational; EX-side training is written at the clock edge.
module bru_bht
  import bru_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int TAG_W     = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_pred_taken_o,
  output logic [XLEN-1:0] if_pred_target_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            is_br_i,
  input  logic            is_uncbr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            true_br_decision_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_DEPTH - 1);

  logic [1:0]       cnt_mem   [BHT_DEPTH];
  logic             valid_mem [BHT_DEPTH];
  logic [TAG_W-1:0] tag_mem   [BHT_DEPTH];
  logic [XLEN-1:0]  tgt_mem   [BHT_DEPTH];

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;

  logic             eq, lt, ltu, cond, taken;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             hit, upd_en, init_wr;
  logic [1:0]       cnt_new;

  bru_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1 (rs1_data_i),
    .rs2 (rs2_data_i),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  assign taken              = is_uncbr_i | (is_br_i & cond);
  assign true_br_decision_o = taken;
  assign mispredict_o       = ex_valid_i &
                              ((taken != ex_pred_taken_i) |
                               (taken & (ex_pred_target_i != ex_target_i)));
  assign redirect_pc_o      = taken ? ex_target_i : ex_pc_i + PC_STEP;

  // Busy covers the reset cycles too, so lookups are suppressed before init starts.
  assign busy_o = rst_i | (state_reg == S_INIT);

  assign if_idx = if_pc_i[IDX_W+1:2];
  assign if_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];
  assign ex_tag = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  assign hit              = valid_mem[if_idx] & (tag_mem[if_idx] == if_tag);
  assign if_pred_taken_o  = ~busy_o & hit & cnt_mem[if_idx][1];
  assign if_pred_target_o = if_pred_taken_o ? tgt_mem[if_idx] : if_pc_i + PC_STEP;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      S_INIT: begin
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == LAST_IDX) state_next = S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign init_wr = ~rst_i & (state_reg == S_INIT);
  assign upd_en  = ex_valid_i & ~busy_o & (is_br_i | is_uncbr_i);
  assign cnt_new = is_uncbr_i ? CNT_ST : sat_update(cnt_mem[ex_idx], taken);

  // Single write port: initialisation sweep, otherwise EX training.
  always_ff @(posedge clk_i) begin
    if (init_wr) begin
      cnt_mem[ptr_reg]   <= CNT_WNT;
      valid_mem[ptr_reg] <= 1'b0;
      tag_mem[ptr_reg]   <= '0;
      tgt_mem[ptr_reg]   <= '0;
    end else if (upd_en) begin
      cnt_mem[ex_idx] <= cnt_new;
      if (taken) begin
        valid_mem[ex_idx] <= 1'b1;
        tag_mem[ex_idx]   <= ex_tag;
        tgt_mem[ex_idx]   <= ex_target_i;
      end
    end
  end

endmodule

// File: tb/tb_bru_bht.sv
// Directed bench for bru_bht: init timing, comparator corners, training,
// BTB aliasing, read-during-write and reset during initialisation.
module tb_bru_bht;
  import bru_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, rs1, rs2, ex_target, ex_pred_target;
  logic        is_br, is_uncbr, ex_pred_taken;
  logic [2:0]  funct3;
  logic        decision, mispredict, busy;
  logic [31:0] redirect;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  bru_bht #(.XLEN(32), .BHT_DEPTH(64), .TAG_W(8)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .if_pc_i            (if_pc),
    .if_pred_taken_o    (pred_taken),
    .if_pred_target_o   (pred_target),
    .ex_valid_i         (ex_valid),
    .ex_pc_i            (ex_pc),
    .rs1_data_i         (rs1),
    .rs2_data_i         (rs2),
    .is_br_i            (is_br),
    .is_uncbr_i         (is_uncbr),
    .funct3_i           (funct3),
    .ex_target_i        (ex_target),
    .ex_pred_taken_i    (ex_pred_taken),
    .ex_pred_target_i   (ex_pred_target),
    .true_br_decision_o (decision),
    .mispredict_o       (mispredict),
    .redirect_pc_o      (redirect),
    .busy_o             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic ex_set(input logic v, input logic br, input logic unc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid = v; is_br = br; is_uncbr = unc; funct3 = f3;
    rs1 = a; rs2 = b; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cmp_step(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic exp);
    @(negedge clk);
    ex_set(1'b0, 1'b1, 1'b0, f3, a, b, 32'h100, 32'h80, 1'b0, 32'h104);
    #1;
    chk(tag, 32'(decision), 32'(exp));
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_t,
                        input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    chk({tag, "_t"}, 32'(pred_taken), 32'(exp_t));
    chk({tag, "_pc"}, pred_target, exp_tgt);
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h100; ex_idle();
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd1);
    lookup("rst_look", 32'h100, 1'b0, 32'h104);

    // One-cycle reset pulse, then count busy cycles
    @(negedge clk); rst = 1'b0; n = 0; #1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 10) lookup("init_look", 32'h100, 1'b0, 32'h104);
      @(negedge clk); #1;
    end
    chk("init_cycles", 32'(n), 32'd64);
    lookup("post_init", 32'h100, 1'b0, 32'h104);

    cmp_step("blt_neg", F3_BLT, 32'h8000_0000, 32'h1, 1'b1);
    cmp_step("bltu_neg", F3_BLTU, 32'h8000_0000, 32'h1, 1'b0);
    cmp_step("bge_neg", F3_BGE, 32'h8000_0000, 32'h1, 1'b0);
    cmp_step("bgeu_neg", F3_BGEU, 32'h8000_0000, 32'h1, 1'b1);
    cmp_step("bne_neg", F3_BNE, 32'h8000_0000, 32'h1, 1'b1);
    cmp_step("beq_ones", F3_BEQ, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    cmp_step("bge_ones", F3_BGE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    cmp_step("bgeu_ones", F3_BGEU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    cmp_step("blt_ones", F3_BLT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cmp_step("f3_010", 3'b010, 32'h5, 32'h5, 1'b0);
    cmp_step("f3_011", 3'b011, 32'h1, 32'h5, 1'b0);

    @(negedge clk);
    ex_set(1'b0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h1, 32'h100, 32'h80, 1'b0, 32'h0);
    #1;
    chk("uncbr_prio", 32'(decision), 32'd1);
    chk("novalid_misp", 32'(mispredict), 32'd0);

    // BEQ at 0x100 taken, predicted not-taken: counter 01 -> 10
    @(negedge clk); if_pc = 32'h100;
    ex_set(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h5, 32'h5, 32'h100, 32'h80, 1'b0, 32'h104);
    #1;
    chk("tr1_dec", 32'(decision), 32'd1);
    chk("tr1_misp", 32'(mispredict), 32'd1);
    chk("tr1_redir", redirect, 32'h80);
    chk("rdw_old_t", 32'(pred_taken), 32'd0);
    chk("rdw_old_pc", pred_target, 32'h104);
    @(negedge clk); ex_idle();
    lookup("rdw_new", 32'h100, 1'b1, 32'h80);
    lookup("alias", 32'h200, 1'b0, 32'h204);

    // Second taken resolve, correctly predicted: 10 -> 11
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h5, 32'h5, 32'h100, 32'h80, 1'b1, 32'h80);
    #1;
    chk("tr2_misp", 32'(mispredict), 32'd0);

    // Not taken while predicted taken: 11 -> 10
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h5, 32'h6, 32'h100, 32'h80, 1'b1, 32'h80);
    #1;
    chk("nt1_dec", 32'(decision), 32'd0);
    chk("nt1_misp", 32'(mispredict), 32'd1);
    chk("nt1_redir", redirect, 32'h104);
    @(negedge clk); ex_idle();
    lookup("cnt10", 32'h100, 1'b1, 32'h80);

    // 10 -> 01 -> 00 -> 00 (saturate), then 00 -> 01 -> 10
    repeat (3) begin
      @(negedge clk);
      ex_set(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h5, 32'h6, 32'h100, 32'h80, 1'b1, 32'h80);
    end
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h7, 32'h7, 32'h100, 32'h80, 1'b0, 32'h104);
    @(negedge clk); ex_idle();
    lookup("sat_low", 32'h100, 1'b0, 32'h104);
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h7, 32'h7, 32'h100, 32'h80, 1'b0, 32'h104);
    @(negedge clk); ex_idle();
    lookup("recover", 32'h100, 1'b1, 32'h80);

    // JAL at 0x200 replaces the aliased entry
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h200, 32'h300, 1'b0, 32'h204);
    #1;
    chk("jal_misp", 32'(mispredict), 32'd1);
    chk("jal_redir", redirect, 32'h300);
    @(negedge clk); ex_idle();
    lookup("jal_look", 32'h200, 1'b1, 32'h300);
    lookup("jal_alias", 32'h100, 1'b0, 32'h104);

    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h200, 32'h340, 1'b1, 32'h300);
    #1;
    chk("jal_tgt_misp", 32'(mispredict), 32'd1);
    chk("jal_tgt_redir", redirect, 32'h340);
    @(negedge clk); ex_idle();
    lookup("jal_newtgt", 32'h200, 1'b1, 32'h340);

    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h200, 32'h340, 1'b1, 32'h340);
    #1;
    chk("jal_ok_misp", 32'(mispredict), 32'd0);

    // Non-branch that was predicted taken
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h200, 32'h999, 1'b1, 32'h340);
    #1;
    chk("nb_dec", 32'(decision), 32'd0);
    chk("nb_misp", 32'(mispredict), 32'd1);
    chk("nb_redir", redirect, 32'h204);
    @(negedge clk); ex_idle();
    lookup("nb_nowrite", 32'h200, 1'b1, 32'h340);

    // PC wrap
    lookup("wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);
    #1;
    chk("wrap_redir", redirect, 32'h0);

    // Reset mid-init at cycle 20, then an EX update during the restarted init
    @(negedge clk); ex_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ex_set(1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h100, 32'h80, 1'b0, 32'h104);
    n = 0; #1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk); ex_idle(); #1;
    end
    chk("reinit_cycles", 32'(n), 32'd64);
    lookup("drop_look", 32'h100, 1'b0, 32'h104);
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h5, 32'h5, 32'h100, 32'h80, 1'b0, 32'h104);
    @(negedge clk); ex_idle();
    lookup("drop_cnt01", 32'h100, 1'b1, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bru_bht.md
Name: bru_bht

Overview:
- Parametrised branch-resolution unit with a bimodal predictor and a direct-mapped branch target buffer (BTB).
- IF stage: indexed by fetch PC; returns a taken prediction and a target.
- EX stage: resolves the real branch outcome from operands and funct3, flags mispredicts, supplies the redirect PC, and trains the tables one cycle later.
- Replaces the plain combinational branch decision block in the 5-stage core.

Parameters:
XLEN, 32, operand/PC width
BHT_DEPTH, 64, entries in counter table and BTB (power of 2, >=4); IDX_W = log2(BHT_DEPTH)
TAG_W, 8, BTB tag bits taken from PC above the index

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
if_pc_i  in  XLEN  fetch PC
if_pred_taken_o  out  1  predicted taken
if_pred_target_o  out  XLEN  predicted next PC
ex_valid_i  in  1  EX instruction valid (not bubble/flushed)
ex_pc_i  in  XLEN  PC of EX instruction
rs1_data_i  in  XLEN  operand 1
rs2_data_i  in  XLEN  operand 2
is_br_i  in  1  conditional branch
is_uncbr_i  in  1  JAL/JALR
funct3_i  in  3  branch condition
ex_target_i  in  XLEN  computed branch/jump target
ex_pred_taken_i  in  1  prediction carried down the pipe
ex_pred_target_i  in  XLEN  predicted target carried down the pipe
true_br_decision_o  out  1  resolved taken
mispredict_o  out  1  redirect required
redirect_pc_o  out  XLEN  correct next PC
busy_o  out  1  table initialisation in progress

Behaviour:
- Index = PC[IDX_W+1:2]. Tag = PC[IDX_W+TAG_W+1:IDX_W+2]. Entry = {cnt[1:0], btb_valid, tag, target}.
- Compare is combinational: sub = rs1 + ~rs2 + 1 at XLEN+1 bits.
  - eq = (sub==0)
  - lt = sub[XLEN-1] ^ overflow
  - ltu = !carry
  - funct3 000 BEQ eq, 001 BNE !eq, 100 BLT lt, 101 BGE !lt, 110 BLTU ltu, 111 BGEU !ltu; 010/011 -> 0.
- true_br_decision_o = is_uncbr_i | (is_br_i & cond). is_uncbr_i has priority.
- All decision/mispredict outputs are combinational and ignore busy_o.
- Mispredict rule, gated by ex_valid_i:
  - mispredict_o = ex_valid_i & ((taken != ex_pred_taken_i) | (taken & ex_pred_target_i != ex_target_i)).
  - A non-branch with ex_pred_taken_i=1 counts as a mispredict (taken=0).
- redirect_pc_o = taken ? ex_target_i : ex_pc_i+4. It is valid whenever mispredict_o=1; otherwise don't-care but deterministic.
- Prediction (combinational):
  - if_pred_taken_o = !busy & btb_valid & tag match & cnt[1].
  - if_pred_target_o = taken ? btb target : if_pc_i+4.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. All arithmetic saturates.
- Table update (registered), when ex_valid_i & !busy:
  - is_br & taken: cnt+1; write valid, tag, target.
  - is_br & !taken: cnt-1; BTB untouched.
  - is_uncbr: cnt=11; write valid, tag, target.
  - Non-branch: no write.
- Read-during-write to the same index: lookup returns the pre-update value; the new value is visible the next cycle.
- Init FSM states: INIT, RUN.
  - rst_i=1 -> state=INIT, ptr=0, busy_o=1. Remains the case while rst_i is held.
  - INIT: each cycle write entry[ptr] = {01, valid=0, tag=0, target=0}, then ptr++. When ptr==BHT_DEPTH-1 is written -> RUN next cycle.
  - Init therefore takes BHT_DEPTH cycles after rst_i falls.
  - rst_i asserted mid-INIT or in RUN restarts from ptr=0.
  - EX updates arriving during INIT are dropped.
- Output values while rst_i=1 or busy_o=1: if_pred_taken_o=0, if_pred_target_o=if_pc_i+4. Combinational outputs follow their inputs.
- PC wrap: pc+4 wraps modulo 2^XLEN.

Decomposition:
- bru_pkg:
  - funct3 constants (F3_BEQ..F3_BGEU)
  - counter encodings (CNT_SNT..CNT_ST)
  - state enum {S_INIT, S_RUN}
  - function sat_update(cnt, taken)
- Sub-module bru_cmp: XLEN-parametrised comparator producing eq/lt/ltu. Purely combinational.
- bru_bht holds the table, the FSM and the mispredict logic.

Test Plan:
- Reset then init: pulse rst_i 1 cycle, BHT_DEPTH=64 -> busy_o=1 for exactly 64 cycles. Every lookup during and after init gives taken=0, target=pc+4.
- Compare corners, XLEN=32, all six funct3:
  - rs1=0x80000000, rs2=0x00000001 -> BLT=1, BLTU=0, BGE=0, BGEU=1.
  - rs1=rs2=0xFFFFFFFF -> BEQ=1, BGE=1, BGEU=1.
  - funct3=010 -> 0.
- Training: BEQ at pc=0x100, target 0x80, taken, resolved twice -> cnt 01->10->11. Lookup 0x100 predicts taken/0x80.
  - Next, one not-taken (ex_pred_taken=1) -> mispredict_o=1, redirect=0x104, cnt=10, still predicts taken.
- JAL at pc=0x200 -> cnt=11. Later resolve with ex_pred_target=0x300 vs ex_target=0x340 -> mispredict_o=1, redirect=0x340, BTB target updated to 0x340.
- Aliasing/hazard:
  - Same index, different tag (pc=0x100 vs 0x100+4*BHT_DEPTH) -> no taken prediction.
  - Lookup and update to the same index in one cycle -> old value that cycle, new value the next.
- Reset mid-init at cycle 20, then EX update during INIT -> init restarts, full 64 cycles. Update dropped; entry still reads 01/invalid.
